// File: rtl/seq_fsm_pkg.sv
// -----------------------------------------------------------------------------
// seq_fsm_pkg
// Shared definitions for the parametrised Moore sequencer:
//   SEQ_IDLE      state encoding of IDLE (step k is encoded as k)
//   seq_exit_e    kind of return to IDLE, which selects the done/timeout pulse
//   seq_state_w   width of the binary state for a given number of steps
//   seq_step_pat  extracts one step pattern from the flattened pattern vector
// -----------------------------------------------------------------------------
package seq_fsm_pkg;

  localparam int SEQ_IDLE       = 0;
  localparam int SEQ_MAX_OUT_W  = 32;
  localparam int SEQ_MAX_FLAT_W = 15 * SEQ_MAX_OUT_W;

  typedef enum logic [1:0] {
    SEQ_EXIT_NONE,
    SEQ_EXIT_DONE,
    SEQ_EXIT_TIMEOUT
  } seq_exit_e;

  // IDLE plus n steps need n+1 binary codes.
  function automatic int seq_state_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Returns the pattern of step k (1-based) in the low bits; bits above out_w
  // belong to the following step, so the caller slices [out_w-1:0].
  function automatic logic [SEQ_MAX_OUT_W-1:0] seq_step_pat(
    input logic [SEQ_MAX_FLAT_W-1:0] flat,
    input int                        out_w,
    input int                        k
  );
    logic [SEQ_MAX_FLAT_W-1:0] shifted;
    shifted = flat >> ((k - 1) * out_w);
    return shifted[SEQ_MAX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/seq_fsm_param_if.sv
// -----------------------------------------------------------------------------
// seq_fsm_param_if
// Control/status bundle of the sequencer.
//   master: drives start, skip, wait_req, abort, timeout_max; reads status
//   slave : the sequencer itself
// Status: zot (step pattern), step_idx (0 = IDLE), busy, done, timeout.
// SW must equal seq_state_w(NUM_STEPS) of the attached sequencer.
// -----------------------------------------------------------------------------
interface seq_fsm_param_if #(
  parameter int OUT_W  = 3,
  parameter int SW     = 2,
  parameter int WAIT_W = 4
);
  logic              start;
  logic              skip;
  logic              wait_req;
  logic              abort;
  logic [WAIT_W-1:0] timeout_max;
  logic [OUT_W-1:0]  zot;
  logic [SW-1:0]     step_idx;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    output start, skip, wait_req, abort, timeout_max,
    input  zot, step_idx, busy, done, timeout
  );

  modport slave (
    input  start, skip, wait_req, abort, timeout_max,
    output zot, step_idx, busy, done, timeout
  );
endinterface

// File: rtl/seq_fsm_param_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
// Hold counter for the last sequencer step.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reset the count to zero (wins over inc)
//   inc        : count one held cycle
//   limit      : hold limit
//   expired    : count has reached limit (combinational compare)
// -----------------------------------------------------------------------------
module seq_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  assign expired = (cnt == limit);

endmodule

// File: rtl/seq_fsm_param.sv
// -----------------------------------------------------------------------------
// seq_fsm_param
// Parametrised Moore sequencer: IDLE plus NUM_STEPS steps, each driving a
// programmable pattern on zot. Binary encoding, IDLE = 0, step k = k.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_fsm_param_if.slave (start/skip/wait_req/abort/timeout_max
//                in; zot/step_idx/busy/done/timeout out)
// Optional feature: define SEQ_TIMEOUT_EN to bound the last-step hold by
// timeout_max (timeout pulse on expiry). Without it the hold is unbounded,
// timeout_max is ignored and timeout stays 0.
// -----------------------------------------------------------------------------
module seq_fsm_param
  import seq_fsm_pkg::*;
#(
  parameter int                         NUM_STEPS = 3,
  parameter int                         OUT_W     = 3,
  parameter logic [NUM_STEPS*OUT_W-1:0] STEP_OUT  = 9'b001_111_101,
  parameter logic [OUT_W-1:0]           IDLE_OUT  = '0,
  parameter int                         SKIP_STEP = 2,
  parameter int                         WAIT_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  seq_fsm_param_if.slave bus
);

  localparam int            SW      = seq_state_w(NUM_STEPS);
  localparam int            NUM_ENC = 1 << SW;
  localparam logic [SW-1:0] IDLE_S  = SW'(SEQ_IDLE);
  localparam logic [SW-1:0] FIRST_S = SW'(1);
  localparam logic [SW-1:0] LAST_S  = SW'(NUM_STEPS);
  localparam logic [SW-1:0] SKIP_S  = SW'(SKIP_STEP);

  // Pattern per encoding; unused encodings map to IDLE_OUT.
  logic [OUT_W-1:0] pat_tbl [NUM_ENC];

  for (genvar g = 0; g < NUM_ENC; g++) begin : g_pat
    if (g >= 1 && g <= NUM_STEPS) begin : g_step
      localparam logic [SEQ_MAX_OUT_W-1:0] PAT =
        seq_step_pat(SEQ_MAX_FLAT_W'(STEP_OUT), OUT_W, g);
      assign pat_tbl[g] = PAT[OUT_W-1:0];
    end else begin : g_idle
      assign pat_tbl[g] = IDLE_OUT;
    end
  end

  logic [SW-1:0]    state, state_nxt;
  seq_exit_e        exit_kind;
  logic             timer_clr, timer_inc, timer_expired;
  logic [OUT_W-1:0] zot_q;
  logic             busy_q, done_q, timeout_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    exit_kind = SEQ_EXIT_NONE;
    timer_inc = 1'b0;

    if (state == IDLE_S) begin
      // abort in IDLE masks start.
      if (bus.start && !bus.abort) state_nxt = FIRST_S;
    end else if (state > LAST_S) begin
      state_nxt = IDLE_S;                    // unused encoding: silent recovery
    end else if (bus.abort) begin
      state_nxt = IDLE_S;
    end else if (state != LAST_S) begin
      if (state == SKIP_S && bus.skip) begin
        state_nxt = IDLE_S;
        exit_kind = SEQ_EXIT_DONE;
      end else begin
        state_nxt = state + FIRST_S;
      end
    end else if (!bus.wait_req) begin
      state_nxt = IDLE_S;
      exit_kind = SEQ_EXIT_DONE;
    end else if (timer_expired) begin
      state_nxt = IDLE_S;
      exit_kind = SEQ_EXIT_TIMEOUT;
    end else begin
      timer_inc = 1'b1;
    end

    // Count starts from zero on every entry into the last step.
    timer_clr = (state_nxt == LAST_S) && (state != LAST_S);
  end

  // All outputs are registered from the next state, so they move on the same
  // edge as the state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE_S;
      zot_q     <= IDLE_OUT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      zot_q     <= pat_tbl[state_nxt];
      busy_q    <= (state_nxt != IDLE_S);
      done_q    <= (exit_kind == SEQ_EXIT_DONE);
      timeout_q <= (exit_kind == SEQ_EXIT_TIMEOUT);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  seq_wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .limit   (bus.timeout_max),
    .expired (timer_expired)
  );
`else
  // No counter: the last step holds for as long as wait_req stays high.
  logic [WAIT_W-1:0] unused_timeout_max;
  logic              unused_timer_ctl;
  assign timer_expired      = 1'b0;
  assign unused_timeout_max = bus.timeout_max;
  assign unused_timer_ctl   = timer_clr ^ timer_inc;
`endif

  assign bus.zot      = zot_q;
  assign bus.step_idx = state;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_seq_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_seq_fsm_param
// Scoreboard bench for seq_fsm_param with default parameters
// (step1=101, step2=111, step3=001, IDLE=000, SKIP_STEP=2).
// Stimulus is applied on the falling edge and the expected status after the
// next rising edge is queued; a monitor pops and compares one entry per
// rising edge (sampled 1 ns later). Timeout vectors are selected with
// SEQ_TIMEOUT_EN, matching the build of the design.
// -----------------------------------------------------------------------------
module tb_seq_fsm_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_fsm_param_if #(.OUT_W(3), .SW(2), .WAIT_W(4)) bus ();

  seq_fsm_param dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] word;   // {zot, step_idx, busy, done, timeout}
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (zot,idx,busy,done,timeout)", name, act[7:0], exp[7:0]);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] z, input logic [1:0] idx,
                                       input logic d, input logic t);
    return {z, idx, (idx != 2'd0), d, t};
  endfunction

  function automatic logic [7:0] dut_word();
    return {bus.zot, bus.step_idx, bus.busy, bus.done, bus.timeout};
  endfunction

  // One clock of stimulus plus the status expected after the following edge.
  task automatic cyc(input logic st, input logic sk, input logic wr, input logic ab,
                     input logic [2:0] z, input logic [1:0] idx,
                     input logic d, input logic t, input string name);
    exp_t e;
    @(negedge clk);
    bus.start    = st;
    bus.skip     = sk;
    bus.wait_req = wr;
    bus.abort    = ab;
    e.word = model(z, idx, d, t);
    e.name = name;
    sb.push_back(e);
  endtask

  // start from IDLE and walk steps 1..3 with the given wait_req level.
  task automatic run_to_last(input logic wr, input string name);
    cyc(1, 0, wr, 0, 3'b101, 2'd1, 0, 0, {name, "_s1"});
    cyc(0, 0, wr, 0, 3'b111, 2'd2, 0, 0, {name, "_s2"});
    cyc(0, 0, wr, 0, 3'b001, 2'd3, 0, 0, {name, "_s3"});
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain(input string name);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: one comparison per rising edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name, 32'(dut_word()), 32'(e.word));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start       = 1'b0;
    bus.skip        = 1'b0;
    bus.wait_req    = 1'b0;
    bus.abort       = 1'b0;
    bus.timeout_max = 4'd15;

    repeat (3) @(negedge clk);
    check("reset", 32'(dut_word()), 32'(model(3'b000, 2'd0, 0, 0)));
    rst_n = 1'b1;

    // Normal pass: 101,111,001 then 000 with done.
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "idle");
    run_to_last(0, "norm");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 1, 0, "norm_done");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "norm_done_clr");

    // Skip at step 2 (skip during step 1 must be ignored); start mid-sequence ignored.
    cyc(1, 1, 0, 0, 3'b101, 2'd1, 0, 0, "skip_s1");
    cyc(1, 1, 0, 0, 3'b111, 2'd2, 0, 0, "skip_s1_ignored");
    cyc(1, 1, 0, 0, 3'b000, 2'd0, 1, 0, "skip_exit");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "skip_idle");

    // start on the cycle the sequence returns to IDLE is not seen.
    run_to_last(0, "restart");
    cyc(1, 0, 0, 0, 3'b000, 2'd0, 1, 0, "restart_exit");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "restart_not_seen");

    // Abort in step 2, abort+start in IDLE, abort while holding in step 3.
    cyc(1, 0, 0, 0, 3'b101, 2'd1, 0, 0, "abort_s1");
    cyc(0, 0, 0, 0, 3'b111, 2'd2, 0, 0, "abort_s2");
    cyc(0, 0, 0, 1, 3'b000, 2'd0, 0, 0, "abort_exit");
    cyc(1, 0, 0, 1, 3'b000, 2'd0, 0, 0, "abort_blocks_start");
    run_to_last(1, "abort_last");
    cyc(0, 0, 1, 1, 3'b000, 2'd0, 0, 0, "abort_last_exit");
    drain("abort");

`ifdef SEQ_TIMEOUT_EN
    // timeout_max=4: last step lasts 5 cycles, then timeout pulse only.
    bus.timeout_max = 4'd4;
    run_to_last(1, "tmo4");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 3'b001, 2'd3, 0, 0, "tmo4_hold");
    cyc(0, 0, 1, 0, 3'b000, 2'd0, 0, 1, "tmo4_exit");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "tmo4_clr");
    // Dropping wait_req before the limit ends with done, not timeout.
    run_to_last(1, "tmo4_drop");
    cyc(0, 0, 1, 0, 3'b001, 2'd3, 0, 0, "tmo4_drop_hold");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 1, 0, "tmo4_drop_done");
    // timeout_max=0: one cycle in the last step.
    bus.timeout_max = 4'd0;
    run_to_last(1, "tmo0");
    cyc(0, 0, 1, 0, 3'b000, 2'd0, 0, 1, "tmo0_exit");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "tmo0_clr");
    drain("tmo");
    bus.timeout_max = 4'd15;
`else
    // No timeout: hold 40 cycles at timeout_max=0, then release.
    bus.timeout_max = 4'd0;
    run_to_last(1, "hold");
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, 3'b001, 2'd3, 0, 0, "hold_40");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 1, 0, "hold_release");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 0, 0, "hold_idle");
    drain("hold");
    bus.timeout_max = 4'd15;
`endif

    // Asynchronous reset between edges while in step 3.
    run_to_last(1, "arst");
    drain("arst_pre");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_immediate", 32'(dut_word()), 32'(model(3'b000, 2'd0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 3'b000, 2'd0, 0, 0, "arst_idle1");
    cyc(0, 0, 1, 0, 3'b000, 2'd0, 0, 0, "arst_idle2");
    cyc(1, 0, 0, 0, 3'b101, 2'd1, 0, 0, "arst_start");
    cyc(0, 0, 0, 0, 3'b111, 2'd2, 0, 0, "arst_s2");
    cyc(0, 0, 0, 0, 3'b001, 2'd3, 0, 0, "arst_s3");
    cyc(0, 0, 0, 0, 3'b000, 2'd0, 1, 0, "arst_done");
    drain("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
